// File: rtl/nl_carry_pipe_pkg.sv
// Shared sizing and nl-vector index helpers for the non-linear carry pipeline.
package nl_carry_pipe_pkg;

  localparam int unsigned DefN   = 32;
  localparam int unsigned DefSeg = 8;

  function automatic int unsigned nl_w(input int unsigned n);
    return 3 * n - 5;
  endfunction

  // Positions 1..n-2 are resolved in the pipe, seg of them per stage.
  function automatic int unsigned n_stages(input int unsigned n, input int unsigned seg);
    return (n - 2 + seg - 1) / seg;
  endfunction

  function automatic int unsigned idx_g(input int unsigned i);
    return 3 * i - 2;
  endfunction

  function automatic int unsigned idx_ac(input int unsigned i);
    return 3 * i - 1;
  endfunction

  function automatic int unsigned idx_bc(input int unsigned i);
    return 3 * i;
  endfunction

endpackage

// File: rtl/nl_carry_pipe_if.sv
// Operand input / product output handshake bundle of the non-linear carry pipeline.
interface nl_carry_pipe_if #(
  parameter int unsigned N = 32
) ();

  localparam int unsigned NlW = nl_carry_pipe_pkg::nl_w(N);

  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_a;
  logic [N-1:0]   out_b;
  logic [NlW-1:0] nl;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_a, out_b, nl
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_a, out_b, nl
  );

endinterface

// File: rtl/nl_carry_seg.sv
// Combinational resolution of one carry segment: per position emits {b&c, a&c, a&b}
// (lowest position in the lowest triple) and ripples the carry as their XOR.
module nl_carry_seg #(
  parameter int unsigned Cnt = 8
) (
  input  logic [Cnt-1:0]   a_i,
  input  logic [Cnt-1:0]   b_i,
  input  logic             c_i,
  output logic [3*Cnt-1:0] nl_o,
  output logic             c_o
);

  logic [Cnt-1:0]   a_sh;
  logic [Cnt-1:0]   b_sh;
  logic [3*Cnt+2:0] tmp;
  logic             c;
  logic             g;
  logic             ac;
  logic             bc;

  // Shift-based walk keeps every select constant.
  always_comb begin
    a_sh = a_i;
    b_sh = b_i;
    c    = c_i;
    nl_o = '0;
    tmp  = '0;
    g    = 1'b0;
    ac   = 1'b0;
    bc   = 1'b0;
    for (int unsigned j = 0; j < Cnt; j++) begin
      g    = a_sh[0] & b_sh[0];
      ac   = a_sh[0] & c;
      bc   = b_sh[0] & c;
      tmp  = {bc, ac, g, nl_o};
      nl_o = tmp[3*Cnt+2:3];
      c    = g ^ ac ^ bc;
      a_sh = a_sh >> 1;
      b_sh = b_sh >> 1;
    end
    c_o = c;
  end

endmodule

// File: rtl/nl_carry_pipe.sv
// Pipelined non-linear front end: registers a/b and builds the AND-product vector nl,
// resolving SEG carry positions per stage behind a valid/ready handshake.
module nl_carry_pipe
  import nl_carry_pipe_pkg::*;
#(
  parameter int unsigned N   = DefN,
  parameter int unsigned SEG = DefSeg
) (
  input logic           clk,
  input logic           rst_n,
  input logic           flush,
  nl_carry_pipe_if.slave io
);

  localparam int unsigned STAGES = n_stages(N, SEG);
  localparam int unsigned NlW    = nl_w(N);

  logic [N-1:0]   a_q  [STAGES];
  logic [N-1:0]   b_q  [STAGES];
  logic [NlW-1:0] nl_q [STAGES];
  logic           c_q  [STAGES];
  logic           v_q  [STAGES];

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] ld;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned Lo    = k * SEG + 1;
    localparam int unsigned Hi    = ((k + 1) * SEG < N - 2) ? (k + 1) * SEG : N - 2;
    localparam int unsigned Cnt   = Hi - Lo + 1;
    localparam int unsigned LoIdx = idx_g(Lo);
    localparam int unsigned HiIdx = idx_bc(Hi);

    logic [N-1:0]     a_src;
    logic [N-1:0]     b_src;
    logic [NlW-1:0]   nl_src;
    logic [NlW-1:0]   nl_d;
    logic [3*Cnt-1:0] seg_nl;
    logic             c_src;
    logic             c_d;
    logic             v_src;

    assign vld[k] = v_q[k];
    // A stage may load unless it and every stage downstream are full and stalled.
    assign ld[k]  = io.out_ready | ~(&vld[STAGES-1:k]);

    if (k == 0) begin : g_first
      assign a_src  = io.in_a;
      assign b_src  = io.in_b;
      assign v_src  = io.in_valid;
      assign c_src  = io.in_a[0] & io.in_b[0];
      assign nl_src = {{(NlW-1){1'b0}}, c_src};
    end else begin : g_next
      assign a_src  = a_q[k-1];
      assign b_src  = b_q[k-1];
      assign v_src  = v_q[k-1];
      assign c_src  = c_q[k-1];
      assign nl_src = nl_q[k-1];
    end

    nl_carry_seg #(
      .Cnt(Cnt)
    ) u_seg (
      .a_i  (a_src[Hi:Lo]),
      .b_i  (b_src[Hi:Lo]),
      .c_i  (c_src),
      .nl_o (seg_nl),
      .c_o  (c_d)
    );

    always_comb begin
      nl_d               = nl_src;
      nl_d[HiIdx:LoIdx]  = seg_nl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q[k]  <= 1'b0;
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        nl_q[k] <= '0;
        c_q[k]  <= 1'b0;
      end else begin
        if (flush) begin
          v_q[k] <= 1'b0;
        end else if (ld[k]) begin
          v_q[k] <= v_src;
        end
        if (ld[k] && v_src && !flush) begin
          a_q[k]  <= a_src;
          b_q[k]  <= b_src;
          nl_q[k] <= nl_d;
          c_q[k]  <= c_d;
        end
      end
    end
  end

  // Flush frees the whole pipe, so the operand offered that cycle is taken and dropped.
  assign io.in_ready  = ld[0] | flush;
  assign io.out_valid = v_q[STAGES-1];
  assign io.out_a     = a_q[STAGES-1];
  assign io.out_b     = b_q[STAGES-1];
  assign io.nl        = nl_q[STAGES-1];

endmodule

// File: tb/tb_nl_carry_pipe.sv
// Scoreboard bench for nl_carry_pipe: independent majority-carry model plus a+b golden check.
module tb_nl_carry_pipe;
  import nl_carry_pipe_pkg::*;

  localparam int unsigned N   = 32;
  localparam int unsigned NLW = 3 * N - 5;
  localparam int unsigned LAT = 4;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [31:0]  cyc;
  } item_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  nl_carry_pipe_if #(.N(N)) io ();

  nl_carry_pipe #(
    .N   (N),
    .SEG (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .io    (io)
  );

  always #5 clk = ~clk;

  item_t       sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pops   = 0;
  logic [31:0] cyc      = '0;
  bit          chk_lat  = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NLW-1:0] model_nl(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [NLW-1:0] v;
    logic           c;
    v    = '0;
    c    = a[0] & b[0];
    v[0] = c;
    for (int i = 1; i <= N - 2; i++) begin
      v[3*i-2] = a[i] & b[i];
      v[3*i-1] = a[i] & c;
      v[3*i]   = b[i] & c;
      c        = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    return v;
  endfunction

  function automatic logic [N-1:0] sum_from_nl(input logic [N-1:0] a, input logic [N-1:0] b,
                                               input logic [NLW-1:0] v);
    logic [N-1:0] s;
    logic         c;
    s[0] = a[0] ^ b[0];
    c    = v[0];
    for (int i = 1; i <= N - 2; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = v[3*i-2] ^ v[3*i-1] ^ v[3*i];
    end
    s[N-1] = a[N-1] ^ b[N-1] ^ c;
    return s;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are decided at the negedge; inputs only move just after posedge.
  always @(negedge clk) begin
    item_t it;
    logic [N-1:0] exp_sum;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (io.out_valid && io.out_ready) begin
        n_pops++;
        if (sb.size() == 0) begin
          check_eq("unexpected_output", 32'(sb.size()), 32'd1);
        end else begin
          it      = sb.pop_front();
          exp_sum = it.a + it.b;
          check_eq("out_a", io.out_a, it.a);
          check_eq("out_b", io.out_b, it.b);
          check_eq("nl", io.nl, model_nl(it.a, it.b));
          check_eq("sum", sum_from_nl(io.out_a, io.out_b, io.nl), exp_sum);
          if (chk_lat) check_eq("latency", cyc - it.cyc, LAT);
        end
      end
      if (flush) sb.delete();
      else if (io.in_valid && io.in_ready) sb.push_back('{a: io.in_a, b: io.in_b, cyc: cyc});
    end
  end

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b);
    int unsigned w = 0;
    io.in_valid = 1'b1;
    io.in_a     = a;
    io.in_b     = b;
    @(negedge clk);
    while (!io.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!io.in_ready) check_eq("send_timeout", io.in_ready, 1'b1);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned w = 0;
    while ((sb.size() != 0 || io.out_valid) && w < 300) begin
      @(negedge clk);
      w++;
    end
    check_eq("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic directed(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [NLW-1:0] exp_nl);
    int lat;
    @(posedge clk);
    #1;
    io.in_valid = 1'b1;
    io.in_a     = a;
    io.in_b     = b;
    @(negedge clk);
    check_eq({tag, "_in_ready"}, io.in_ready, 1'b1);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    lat = 1;
    while (!io.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, "_latency"}, lat, LAT);
    check_eq({tag, "_out_valid"}, io.out_valid, 1'b1);
    check_eq({tag, "_nl_const"}, io.nl, exp_nl);
    drain();
  endtask

  initial begin
    logic [NLW-1:0] exp_nl;
    logic [N-1:0]   cap_a;
    logic [NLW-1:0] cap_nl;
    int             pops0;

    io.in_valid  = 1'b0;
    io.in_a      = '0;
    io.in_b      = '0;
    io.out_ready = 1'b1;

    #3;
    check_eq("rst_out_valid", io.out_valid, 1'b0);
    check_eq("rst_nl", io.nl, '0);
    check_eq("rst_out_a", io.out_a, '0);
    check_eq("rst_in_ready", io.in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // a = all ones, b = 1: carry ripples the full width, every triple is {0,1,0}.
    exp_nl    = '0;
    exp_nl[0] = 1'b1;
    for (int i = 1; i <= N - 2; i++) exp_nl[3*i-1] = 1'b1;
    directed("ones_plus_one", 32'hFFFF_FFFF, 32'h0000_0001, exp_nl);

    // Low half all ones in both operands: triples 1..15 saturate, above are zero.
    exp_nl    = '0;
    exp_nl[0] = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      exp_nl[3*i-2] = 1'b1;
      exp_nl[3*i-1] = 1'b1;
      exp_nl[3*i]   = 1'b1;
    end
    directed("low_half", 32'h0000_FFFF, 32'h0000_FFFF, exp_nl);

    // Back-to-back stream with no back-pressure.
    @(posedge clk);
    #1;
    chk_lat = 1'b1;
    pops0   = n_pops;
    for (int i = 0; i < 100; i++) send($urandom, $urandom);
    drain();
    chk_lat = 1'b0;
    check_eq("stream_count", n_pops - pops0, 100);

    // Mid-stream stall of 10 cycles.
    @(posedge clk);
    #1;
    pops0 = n_pops;
    fork
      begin
        for (int i = 0; i < 40; i++) send($urandom, $urandom);
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        io.out_ready = 1'b0;
        @(negedge clk);
        cap_a  = io.out_a;
        cap_nl = io.nl;
        repeat (9) @(negedge clk);
        check_eq("stall_in_ready", io.in_ready, 1'b0);
        check_eq("stall_out_valid", io.out_valid, 1'b1);
        check_eq("stall_hold_a", io.out_a, cap_a);
        check_eq("stall_hold_nl", io.nl, cap_nl);
        @(posedge clk);
        #1;
        io.out_ready = 1'b1;
      end
    join
    drain();
    check_eq("stall_count", n_pops - pops0, 40);

    // Flush with three entries in flight; an operand offered during flush is dropped.
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send($urandom, $urandom);
    flush       = 1'b1;
    io.in_valid = 1'b1;
    io.in_a     = 32'h1234_5678;
    io.in_b     = 32'h9ABC_DEF0;
    @(negedge clk);
    check_eq("flush_in_ready", io.in_ready, 1'b1);
    @(posedge clk);
    #1;
    flush       = 1'b0;
    io.in_valid = 1'b0;
    check_eq("flush_out_valid", io.out_valid, 1'b0);
    pops0 = n_pops;
    repeat (10) @(negedge clk);
    check_eq("flush_no_emit", n_pops - pops0, 0);

    // Asynchronous reset mid-stream.
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) send($urandom, $urandom);
    #2;
    check_eq("prerst_out_valid", io.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", io.out_valid, 1'b0);
    check_eq("arst_nl", io.nl, '0);
    check_eq("arst_out_a", io.out_a, '0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    check_eq("postrst_in_ready", io.in_ready, 1'b1);
    check_eq("postrst_out_valid", io.out_valid, 1'b0);

    @(posedge clk);
    #1;
    send(32'h8000_0000, 32'h8000_0000);
    send(32'h7FFF_FFFF, 32'h0000_0001);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
